// File: rtl/lockstep_divergence_monitor.sv
// Lockstep divergence monitor.
// Compares the ROB enqueue streams of a DUT core and a variant core lane by lane.
// It latches the first divergence (cycle and lowest failing lane), then counts
// commits until both cores have committed DONE_INST or a programmable timeout
// expires. Reset is expected to be deasserted synchronously to clock by the
// surrounding testbench top.
module lockstep_divergence_monitor #(
    parameter int                LANES     = 2,
    parameter int                INST_W    = 32,
    parameter logic [INST_W-1:0] DONE_INST = 32'h00302013,
    parameter int                CNT_W     = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [CNT_W-1:0]          timeout_limit,
    input  logic [LANES-1:0]          dut_enq_valid,
    input  logic [LANES*INST_W-1:0]   dut_enq_inst,
    input  logic [LANES-1:0]          vnt_enq_valid,
    input  logic [LANES*INST_W-1:0]   vnt_enq_inst,
    input  logic [LANES-1:0]          dut_cmt_valid,
    input  logic [LANES*INST_W-1:0]   dut_cmt_inst,
    input  logic [LANES-1:0]          vnt_cmt_valid,
    input  logic [LANES*INST_W-1:0]   vnt_cmt_inst,
    output logic                      in_sync,
    output logic [$clog2(LANES):0]    div_lane,
    output logic [CNT_W-1:0]          div_cycle,
    output logic [CNT_W-1:0]          dut_commits,
    output logic [CNT_W-1:0]          vnt_commits,
    output logic                      dut_done,
    output logic                      vnt_done,
    output logic                      finished,
    output logic                      timed_out
);

    localparam int LW = $clog2(LANES) + 1;

    typedef enum logic [1:0] {
        SYNC     = 2'd0,
        DIVERGED = 2'd1,
        DONE     = 2'd2,
        TIMEOUT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  elapsed;
    logic [CNT_W:0]    elapsed_inc;

    logic [LANES-1:0]  lane_mismatch;
    logic              any_mismatch;
    logic [LW-1:0]     first_lane;

    logic              dut_hit;
    logic              vnt_hit;
    logic              dut_done_nx;
    logic              vnt_done_nx;
    logic              timeout_hit;

    // Saturating add: clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Number of set valid bits, widened to counter width.
    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // True when any valid commit lane carries the end-of-run marker.
    function automatic logic has_marker(input logic [LANES-1:0]        v,
                                        input logic [LANES*INST_W-1:0] inst);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i] && (inst[i*INST_W +: INST_W] == DONE_INST)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Per-lane enqueue compare; instructions only matter when both lanes are valid.
    always_comb begin
        lane_mismatch = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mismatch[i] = (dut_enq_valid[i] != vnt_enq_valid[i]) ||
                               (dut_enq_valid[i] &&
                                (dut_enq_inst[i*INST_W +: INST_W] !=
                                 vnt_enq_inst[i*INST_W +: INST_W]));
        end
    end

    // Priority-encode the lowest mismatching lane.
    always_comb begin
        first_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_mismatch[i]) begin
                first_lane = LW'(i);
            end
        end
    end

    assign any_mismatch = |lane_mismatch;
    assign dut_hit      = has_marker(dut_cmt_valid, dut_cmt_inst);
    assign vnt_hit      = has_marker(vnt_cmt_valid, vnt_cmt_inst);
    assign dut_done_nx  = dut_done | dut_hit;
    assign vnt_done_nx  = vnt_done | vnt_hit;
    assign elapsed_inc  = {1'b0, elapsed} + (CNT_W+1)'(1);
    assign timeout_hit  = (timeout_limit != '0) &&
                          (elapsed_inc == {1'b0, timeout_limit});

    // Next-state logic; completion beats timeout, clear beats everything.
    always_comb begin
        state_nx = state;
        case (state)
            SYNC: begin
                if (any_mismatch) begin
                    state_nx = DIVERGED;
                end
            end
            DIVERGED: begin
                if (dut_done_nx && vnt_done_nx) begin
                    state_nx = DONE;
                end else if (timeout_hit) begin
                    state_nx = TIMEOUT;
                end
            end
            default: begin
                state_nx = state;
            end
        endcase
        if (clear) begin
            state_nx = SYNC;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SYNC;
        end else begin
            state <= state_nx;
        end
    end

    // Counters and latched divergence/completion status; frozen in terminal states.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            elapsed     <= '0;
            in_sync     <= 1'b1;
            div_lane    <= '0;
            div_cycle   <= '0;
            dut_commits <= '0;
            vnt_commits <= '0;
            dut_done    <= 1'b0;
            vnt_done    <= 1'b0;
        end else if (clear) begin
            cycle_cnt   <= '0;
            elapsed     <= '0;
            in_sync     <= 1'b1;
            div_lane    <= '0;
            div_cycle   <= '0;
            dut_commits <= '0;
            vnt_commits <= '0;
            dut_done    <= 1'b0;
            vnt_done    <= 1'b0;
        end else begin
            cycle_cnt <= sat_add(cycle_cnt, CNT_W'(1));
            case (state)
                SYNC: begin
                    if (any_mismatch) begin
                        in_sync   <= 1'b0;
                        div_lane  <= first_lane;
                        div_cycle <= cycle_cnt;
                        elapsed   <= '0;
                    end
                end
                DIVERGED: begin
                    dut_commits <= sat_add(dut_commits, popcount(dut_cmt_valid));
                    vnt_commits <= sat_add(vnt_commits, popcount(vnt_cmt_valid));
                    dut_done    <= dut_done_nx;
                    vnt_done    <= vnt_done_nx;
                    elapsed     <= sat_add(elapsed, CNT_W'(1));
                end
                default: begin
                    elapsed <= elapsed;
                end
            endcase
        end
    end

    assign finished  = (state == DONE);
    assign timed_out = (state == TIMEOUT);

endmodule

// File: tb/tb_lockstep_divergence_monitor.sv
// Bench for lockstep_divergence_monitor: a 2-lane instance for the lane compare
// table and the multi-cycle sequences, a 4-lane instance for multi-commit counting.
module tb_lockstep_divergence_monitor;

    localparam logic [31:0] DONE = 32'h00302013;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] IA   = 32'h1111_0001;
    localparam logic [31:0] IB   = 32'h2222_0002;
    localparam logic [31:0] IC   = 32'h3333_0003;
    localparam logic [31:0] ID   = 32'h4444_0004;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // 2-lane instance
    logic        a_clear;
    logic [31:0] a_tl;
    logic [1:0]  a_dev, a_vev, a_dcv, a_vcv;
    logic [63:0] a_dei, a_vei, a_dci, a_vci;
    logic        a_in_sync, a_dut_done, a_vnt_done, a_finished, a_timed_out;
    logic [1:0]  a_div_lane;
    logic [31:0] a_div_cycle, a_dut_commits, a_vnt_commits;

    // 4-lane instance
    logic         b_clear;
    logic [31:0]  b_tl;
    logic [3:0]   b_dev, b_vev, b_dcv, b_vcv;
    logic [127:0] b_dei, b_vei, b_dci, b_vci;
    logic         b_in_sync, b_dut_done, b_vnt_done, b_finished, b_timed_out;
    logic [2:0]   b_div_lane;
    logic [31:0]  b_div_cycle, b_dut_commits, b_vnt_commits;

    lockstep_divergence_monitor #(.LANES(2)) u_a (
        .clock(clock), .reset(reset), .clear(a_clear), .timeout_limit(a_tl),
        .dut_enq_valid(a_dev), .dut_enq_inst(a_dei),
        .vnt_enq_valid(a_vev), .vnt_enq_inst(a_vei),
        .dut_cmt_valid(a_dcv), .dut_cmt_inst(a_dci),
        .vnt_cmt_valid(a_vcv), .vnt_cmt_inst(a_vci),
        .in_sync(a_in_sync), .div_lane(a_div_lane), .div_cycle(a_div_cycle),
        .dut_commits(a_dut_commits), .vnt_commits(a_vnt_commits),
        .dut_done(a_dut_done), .vnt_done(a_vnt_done),
        .finished(a_finished), .timed_out(a_timed_out)
    );

    lockstep_divergence_monitor #(.LANES(4)) u_b (
        .clock(clock), .reset(reset), .clear(b_clear), .timeout_limit(b_tl),
        .dut_enq_valid(b_dev), .dut_enq_inst(b_dei),
        .vnt_enq_valid(b_vev), .vnt_enq_inst(b_vei),
        .dut_cmt_valid(b_dcv), .dut_cmt_inst(b_dci),
        .vnt_cmt_valid(b_vcv), .vnt_cmt_inst(b_vci),
        .in_sync(b_in_sync), .div_lane(b_div_lane), .div_cycle(b_div_cycle),
        .dut_commits(b_dut_commits), .vnt_commits(b_vnt_commits),
        .dut_done(b_dut_done), .vnt_done(b_vnt_done),
        .finished(b_finished), .timed_out(b_timed_out)
    );

    typedef struct {
        logic [1:0]  dv;
        logic [63:0] di;
        logic [1:0]  vv;
        logic [63:0] vi;
        logic        exp_sync;
        logic [1:0]  exp_lane;
    } vec_t;

    typedef struct {
        logic        in_sync;
        logic [2:0]  lane;
        logic [31:0] cyc;
        logic [31:0] dc;
        logic [31:0] vc;
    } exp_t;

    vec_t vecs[9];
    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_idle();
        a_dev = '0; a_vev = '0; a_dcv = '0; a_vcv = '0;
        a_dei = '0; a_vei = '0; a_dci = '0; a_vci = '0;
    endtask

    task automatic b_idle();
        b_dev = '0; b_vev = '0; b_dcv = '0; b_vcv = '0;
        b_dei = '0; b_vei = '0; b_dci = '0; b_vci = '0;
    endtask

    // Leaves the next driven inputs as cycle 0 of a fresh run.
    task automatic a_restart();
        a_idle();
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
    endtask

    task automatic b_restart();
        b_idle();
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;

        vecs[0] = '{dv:2'b11, di:{IA,IB}, vv:2'b11, vi:{IA,IB}, exp_sync:1'b1, exp_lane:2'd0};
        vecs[1] = '{dv:2'b00, di:{IA,IB}, vv:2'b00, vi:{IC,ID}, exp_sync:1'b1, exp_lane:2'd0};
        vecs[2] = '{dv:2'b01, di:{IA,IB}, vv:2'b00, vi:{IA,IB}, exp_sync:1'b0, exp_lane:2'd0};
        vecs[3] = '{dv:2'b10, di:{IA,IB}, vv:2'b10, vi:{IC,IB}, exp_sync:1'b0, exp_lane:2'd1};
        vecs[4] = '{dv:2'b11, di:{IA,IB}, vv:2'b11, vi:{IC,ID}, exp_sync:1'b0, exp_lane:2'd0};
        vecs[5] = '{dv:2'b11, di:{IA,IB}, vv:2'b10, vi:{IA,IB}, exp_sync:1'b0, exp_lane:2'd0};
        vecs[6] = '{dv:2'b10, di:{IA,IB}, vv:2'b11, vi:{IA,IB}, exp_sync:1'b0, exp_lane:2'd0};
        vecs[7] = '{dv:2'b01, di:{IA,IB}, vv:2'b01, vi:{IC,IB}, exp_sync:1'b1, exp_lane:2'd0};
        vecs[8] = '{dv:2'b11, di:{IA,IB}, vv:2'b11, vi:{IA ^ 32'h8000_0000, IB},
                    exp_sync:1'b0, exp_lane:2'd1};

        reset = 1'b0; a_clear = 1'b0; b_clear = 1'b0; a_tl = '0; b_tl = '0;
        a_idle(); b_idle();
        repeat (2) @(posedge clock);
        #1;
        chk("rst in_sync", a_in_sync, 1);
        chk("rst div_lane", a_div_lane, 0);
        chk("rst div_cycle", a_div_cycle, 0);
        chk("rst commits", {a_dut_commits, a_vnt_commits}, 0);
        chk("rst flags", {a_dut_done, a_vnt_done, a_finished, a_timed_out}, 0);
        reset = 1'b1;

        // Identical random streams, with markers committed, for 1000 cycles.
        for (int c = 0; c < 1000; c++) begin
            a_dev = 2'($urandom_range(0, 3));
            a_vev = a_dev;
            a_dei = {$urandom, $urandom};
            a_vei = a_dei;
            if (!a_dev[0]) a_vei[31:0]  = ~a_dei[31:0];
            if (!a_dev[1]) a_vei[63:32] = ~a_dei[63:32];
            a_dcv = 2'($urandom_range(0, 3));
            a_vcv = 2'($urandom_range(0, 3));
            a_dci = {DONE, NOP};
            a_vci = {DONE, DONE};
            tick();
        end
        a_idle();
        chk("ident in_sync", a_in_sync, 1);
        chk("ident counters", {a_div_cycle, a_dut_commits, a_vnt_commits}, 0);
        chk("ident flags", {a_dut_done, a_vnt_done, a_finished, a_timed_out}, 0);

        // Lane compare table: scoreboard pushed on drive, popped after the edge.
        for (int i = 0; i < 9; i++) begin
            a_restart();
            a_dev = vecs[i].dv; a_dei = vecs[i].di;
            a_vev = vecs[i].vv; a_vei = vecs[i].vi;
            e.in_sync = vecs[i].exp_sync; e.lane = {1'b0, vecs[i].exp_lane};
            e.cyc = 0; e.dc = 0; e.vc = 0;
            sbq.push_back(e);
            tick();
            a_idle();
            e = sbq.pop_front();
            chk($sformatf("vec%0d in_sync", i), a_in_sync, e.in_sync);
            chk($sformatf("vec%0d div_lane", i), a_div_lane, e.lane);
            chk($sformatf("vec%0d div_cycle", i), a_div_cycle, e.cyc);
        end

        // Clear wins over a simultaneous mismatch.
        a_idle();
        a_dev = 2'b01;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        a_idle();
        chk("clear vs mismatch in_sync", a_in_sync, 1);

        // Lane1 instruction differs at cycle 50.
        a_restart();
        for (int c = 0; c <= 50; c++) begin
            a_dev = 2'b11; a_vev = 2'b11;
            a_dei = {IA + 32'(c), IB}; a_vei = a_dei;
            if (c == 50) a_vei[63:32] = IC;
            tick();
            if (c == 49) chk("c50 pre in_sync", a_in_sync, 1);
        end
        a_idle();
        chk("c50 in_sync", a_in_sync, 0);
        chk("c50 div_lane", a_div_lane, 1);
        chk("c50 div_cycle", a_div_cycle, 50);

        // Lane0 valid on DUT only at cycle 20; markers at 30 (DUT) and 40 (variant).
        a_restart();
        for (int c = 0; c <= 20; c++) begin
            a_idle();
            a_dev = 2'b11; a_vev = 2'b11;
            a_dei = {IA, IB}; a_vei = a_dei;
            if (c == 20) begin
                a_vev = 2'b10;
                a_dcv = 2'b11; a_dci = {DONE, NOP};
                a_vcv = 2'b11; a_vci = {DONE, DONE};
            end
            tick();
        end
        chk("c20 div_lane", a_div_lane, 0);
        chk("c20 div_cycle", a_div_cycle, 20);
        chk("c20 uncounted", {a_dut_commits, a_vnt_commits}, 0);
        chk("c20 no done", {a_dut_done, a_vnt_done}, 0);
        for (int c = 21; c <= 40; c++) begin
            a_idle();
            a_dev = 2'b01;
            a_dcv = 2'b01; a_dci = {NOP, NOP};
            if (c == 30) begin a_dcv = 2'b11; a_dci = {DONE, NOP}; end
            if (c == 40) begin a_vcv = 2'b01; a_vci = {NOP, DONE}; end
            tick();
            if (c == 29) chk("c29 dut_done", a_dut_done, 0);
            if (c == 30) chk("c30 done flags", {a_dut_done, a_vnt_done}, 2'b10);
            if (c == 39) chk("c39 finished", a_finished, 0);
        end
        chk("c40 finished", a_finished, 1);
        chk("c40 timed_out", a_timed_out, 0);
        chk("c40 dut_commits", a_dut_commits, 21);
        chk("c40 vnt_commits", a_vnt_commits, 1);
        for (int c = 0; c < 3; c++) begin
            a_dev = 2'b01; a_dcv = 2'b11; a_vcv = 2'b11;
            tick();
        end
        chk("done frozen commits", {a_dut_commits, a_vnt_commits}, {32'd21, 32'd1});
        chk("done frozen lane/cycle", {a_div_lane, a_div_cycle}, {2'd0, 32'd20});
        chk("done frozen finished", a_finished, 1);
        a_idle();
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk("clear in_sync", a_in_sync, 1);
        chk("clear flags", {a_dut_done, a_vnt_done, a_finished, a_timed_out}, 0);
        chk("clear counters", {a_div_cycle, a_dut_commits, a_vnt_commits}, 0);

        // Markers before divergence are ignored; both markers in one cycle later.
        a_restart();
        for (int c = 0; c <= 7; c++) begin
            a_idle();
            if (c == 2) begin
                a_dcv = 2'b01; a_dci = {NOP, DONE};
                a_vcv = 2'b01; a_vci = {NOP, DONE};
            end
            if (c == 5) a_vev = 2'b10;
            if (c == 7) begin
                a_dcv = 2'b10; a_dci = {DONE, NOP};
                a_vcv = 2'b01; a_vci = {NOP, DONE};
            end
            tick();
            if (c == 4) chk("pre-div markers", {a_dut_done, a_vnt_done, a_in_sync}, 3'b001);
            if (c == 5) chk("late div lane", a_div_lane, 1);
            if (c == 6) chk("same-cycle pre", a_finished, 0);
        end
        chk("same-cycle finished", a_finished, 1);
        chk("same-cycle flags", {a_dut_done, a_vnt_done}, 2'b11);

        // Timeout of 10 with no markers.
        a_tl = 32'd10;
        a_restart();
        for (int c = 0; c <= 13; c++) begin
            a_idle();
            if (c == 3) a_dev = 2'b01;
            if (c >= 4) a_dcv = 2'b01;
            tick();
            if (c == 12) chk("to pre timed_out", a_timed_out, 0);
        end
        chk("to timed_out", a_timed_out, 1);
        chk("to finished", a_finished, 0);
        chk("to dut_commits", a_dut_commits, 10);
        for (int c = 0; c < 2; c++) begin
            a_dcv = 2'b11; a_vcv = 2'b11;
            tick();
        end
        chk("to frozen", {a_dut_commits, a_vnt_commits, 31'd0, a_timed_out},
            {32'd10, 32'd0, 32'd1});

        // Last marker on the timeout cycle: completion wins.
        a_restart();
        for (int c = 0; c <= 13; c++) begin
            a_idle();
            if (c == 3) a_dev = 2'b01;
            if (c == 5) begin a_dcv = 2'b01; a_dci = {NOP, DONE}; end
            if (c == 13) begin a_vcv = 2'b10; a_vci = {DONE, NOP}; end
            tick();
            if (c == 12) chk("race pre", {a_finished, a_timed_out}, 0);
        end
        chk("race finished", {a_finished, a_timed_out}, 2'b10);
        a_tl = '0;

        // Asynchronous reset between edges while diverged.
        a_restart();
        for (int c = 0; c <= 4; c++) begin
            a_idle();
            if (c == 1) a_vev = 2'b01;
            if (c >= 2) a_dcv = 2'b01;
            tick();
        end
        chk("pre-rst div", {a_in_sync, a_div_cycle, a_dut_commits}, {1'b0, 32'd1, 32'd3});
        #2 reset = 1'b0;
        #1;
        chk("async rst in_sync", a_in_sync, 1);
        chk("async rst counters", {a_div_cycle, a_dut_commits}, 0);
        chk("async rst flags", {a_dut_done, a_finished, a_timed_out}, 0);
        #2 reset = 1'b1;
        a_idle();

        // 4 lanes: divergence on lane 2, then 3 and 2 commits per cycle.
        b_restart();
        b_dev = 4'b1111; b_vev = 4'b1111;
        b_dei = {IA, IB, IC, ID};
        b_vei = {IB, IA, IC, ID};
        tick();
        b_idle();
        chk("b div_lane", b_div_lane, 2);
        chk("b div_cycle", b_div_cycle, 0);
        for (int k = 1; k <= 4; k++) begin
            b_dcv = 4'b1011; b_dci = {NOP, NOP, NOP, NOP};
            b_vcv = 4'b0110; b_vci = {NOP, NOP, NOP, NOP};
            e.in_sync = 1'b0; e.lane = 3'd2; e.cyc = 0;
            e.dc = 32'(3 * k); e.vc = 32'(2 * k);
            sbq.push_back(e);
            tick();
            e = sbq.pop_front();
            chk($sformatf("b step%0d dut", k), b_dut_commits, e.dc);
            chk($sformatf("b step%0d vnt", k), b_vnt_commits, e.vc);
            chk($sformatf("b step%0d state", k), {b_in_sync, b_div_lane, b_div_cycle},
                {e.in_sync, e.lane, e.cyc});
        end
        b_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
